// File: rtl/ws2812_multi.sv
// Parallel multi-strip WS2812/SK6812 driver with one shared bit-timing engine.
// Define WS2812_BRIGHTNESS_EN to scale each byte by the brightness input.
module ws2812_multi #(
   parameter int NUM_CHAN      = 4,
   parameter int LEDS_PER_CHAN = 8,
   parameter int BITS_PER_LED  = 24,
   parameter int CLK_MHZ       = 12,
   parameter int T_PERIOD      = (CLK_MHZ * 125 + 99) / 100,
   parameter int T_ON          = (CLK_MHZ * 90 + 99) / 100,
   parameter int T_OFF         = (CLK_MHZ * 35 + 99) / 100,
   parameter int T_RESET       = CLK_MHZ * 280,
   parameter int CONTINUOUS    = 1,
   localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
   localparam int LW = (LEDS_PER_CHAN > 1) ? $clog2(LEDS_PER_CHAN) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [CW-1:0]           wr_chan,
   input  logic [LW-1:0]           wr_led,
   input  logic [BITS_PER_LED-1:0] wr_data,
   input  logic                    start,
   input  logic [7:0]              brightness,
   output logic [NUM_CHAN-1:0]     data_out,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int BW = $clog2(BITS_PER_LED);
   localparam int PW = $clog2(T_PERIOD + 1);
   localparam int RW = $clog2(T_RESET + 1);
   localparam logic [PW-1:0] TON  = PW'(T_ON);
   localparam logic [PW-1:0] TOFF = PW'(T_OFF);
   localparam logic [PW-1:0] TLST = PW'(T_PERIOD - 1);
   localparam logic [BW-1:0] BLST = BW'(BITS_PER_LED - 1);
   localparam logic [LW-1:0] LLST = LW'(LEDS_PER_CHAN - 1);
   localparam logic [RW-1:0] RLST = RW'(T_RESET - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DATA, LATCH} state_t;

   state_t                  state;
   logic [PW-1:0]           cnt;
   logic [BW-1:0]           bit_idx;
   logic [LW-1:0]           led_idx;
   logic [RW-1:0]           lcnt;
   logic                    load_ph;
   logic [LW-1:0]           rd_addr;
   logic                    wr_ok;
   logic [BITS_PER_LED-1:0] mem     [NUM_CHAN][LEDS_PER_CHAN];
   logic [BITS_PER_LED-1:0] rd_data [NUM_CHAN];
   logic [BITS_PER_LED-1:0] shreg   [NUM_CHAN];

`ifdef WS2812_BRIGHTNESS_EN
   function automatic logic [BITS_PER_LED-1:0] prep(
      input logic [BITS_PER_LED-1:0] w
   );
      logic [BITS_PER_LED-1:0] r;
      r = '0;
      for (int b = 0; b < BITS_PER_LED / 8; b++) begin
         r[b*8 +: 8] = 8'((16'(w[b*8 +: 8]) * 16'(brightness)
                           + 16'(w[b*8 +: 8])) >> 8);
      end
      return r;
   endfunction
`else
   wire unused_brightness = ^brightness;

   function automatic logic [BITS_PER_LED-1:0] prep(
      input logic [BITS_PER_LED-1:0] w
   );
      return w;
   endfunction
`endif

   assign wr_ok = {1'b0, wr_led} < (LW + 1)'(LEDS_PER_CHAN);

   // Prefetch the next LED while the current one shifts out.
   always_comb begin
      rd_addr = '0;
      if (state == DATA && led_idx != LLST) begin
         rd_addr = led_idx + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (wr_en && wr_chan == CW'(c) && wr_ok) begin
            mem[c][wr_led] <= wr_data;
         end
         rd_data[c] <= mem[c][rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= (CONTINUOUS != 0) ? LATCH : IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         led_idx    <= '0;
         lcnt       <= RLST;
         load_ph    <= 1'b0;
         data_out   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               data_out <= '0;
               if (start) begin
                  state   <= LOAD;
                  load_ph <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            LOAD: begin
               load_ph <= 1'b1;
               if (load_ph) begin
                  for (int c = 0; c < NUM_CHAN; c++) begin
                     shreg[c] <= prep(rd_data[c]);
                  end
                  data_out <= '1;
                  cnt      <= '0;
                  bit_idx  <= '0;
                  led_idx  <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (cnt == TLST) begin
                  cnt <= '0;
                  if (bit_idx == BLST) begin
                     bit_idx <= '0;
                     if (led_idx == LLST) begin
                        state      <= LATCH;
                        lcnt       <= RLST;
                        data_out   <= '0;
                        frame_done <= (T_RESET == 1);
                     end else begin
                        led_idx <= led_idx + LW'(1);
                        for (int c = 0; c < NUM_CHAN; c++) begin
                           shreg[c] <= prep(rd_data[c]);
                        end
                        data_out <= '1;
                     end
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                     for (int c = 0; c < NUM_CHAN; c++) begin
                        shreg[c] <= shreg[c] << 1;
                     end
                     data_out <= '1;
                  end
               end else begin
                  cnt <= cnt + PW'(1);
                  for (int c = 0; c < NUM_CHAN; c++) begin
                     data_out[c] <= (cnt + PW'(1)) <
                        (shreg[c][BITS_PER_LED-1] ? TON : TOFF);
                  end
               end
            end
            LATCH: begin
               data_out <= '0;
               if (lcnt == '0) begin
                  if (CONTINUOUS != 0) begin
                     state   <= LOAD;
                     load_ph <= 1'b0;
                     busy    <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  lcnt       <= lcnt - RW'(1);
                  frame_done <= (lcnt == RW'(1));
               end
            end
         endcase
      end
   end

endmodule

// File: doc/ws2812_multi.md
Name: ws2812_multi

Overview:
- Parallel multi-strip WS2812/SK6812 driver; NUM_CHAN independent serial outputs share one bit-timing engine and shift frames simultaneously.
- Per-channel LED frame buffer, configurable bits per LED (24 RGB / 32 RGBW) and clock-derived timing.
- Selectable free-running refresh or one-shot frames with busy/done handshake.
- Sits between the pattern generator / host register bus and the LED strip pins.

Parameters:
- NUM_CHAN, 4, number of parallel strips (1..16)
- LEDS_PER_CHAN, 8, LEDs per strip (1..256)
- BITS_PER_LED, 24, bits per LED word (24 or 32), sent MSB first
- CLK_MHZ, 12, clock frequency; sets timing defaults
- T_PERIOD, ceil(CLK_MHZ*1.25), bit period in clocks
- T_ON, ceil(CLK_MHZ*0.9), high clocks for a '1' bit (T_ON < T_PERIOD)
- T_OFF, ceil(CLK_MHZ*0.35), high clocks for a '0' bit (T_OFF < T_ON)
- T_RESET, CLK_MHZ*280, latch gap in clocks, output low
- CONTINUOUS, 1, 1 = auto-refresh forever; 0 = one frame per start

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  frame-buffer write strobe
- wr_chan  in  max(1,clog2(NUM_CHAN))  target strip
- wr_led  in  max(1,clog2(LEDS_PER_CHAN))  target LED index; 0 = first LED on strip
- wr_data  in  BITS_PER_LED  LED word, stored as sent (caller orders GRB/GRBW)
- start  in  1  one-shot frame request; ignored when CONTINUOUS=1
- brightness  in  8  global brightness; used only with the optional feature
- data_out  out  NUM_CHAN  serial line per strip
- busy  out  1  high from frame acceptance to end of latch gap
- frame_done  out  1  one-cycle pulse on the last latch-gap cycle

Behaviour:
- Reset values: data_out=0, busy=0, frame_done=0; state=LATCH with counter=T_RESET if CONTINUOUS=1, else IDLE. Frame-buffer contents are not reset (BRAM inference).
- Writes: captured at the clk edge when wr_en=1. Writes with wr_chan>=NUM_CHAN or wr_led>=LEDS_PER_CHAN are ignored. Writes are legal at any time. An LED word already loaded into the shift register is unaffected; later LEDs see the new value in the current frame.
- Storage: one array per channel, each with a single write port and a single registered read port; all channels read the same LED index in the same cycle.
- States:
  - IDLE: data_out=0. start=1 -> LOAD; busy=1 from the next cycle.
  - LOAD: exactly 2 cycles; presents LED 0 address, then registers the word into per-channel shift registers -> DATA.
  - DATA: bit counter runs 0..T_PERIOD-1. data_out[c]=1 while counter < (bit ? T_ON : T_OFF), else 0. The next LED word is prefetched during the current LED, so bits are contiguous with no gap between LEDs. After bit 0 of LED LEDS_PER_CHAN-1 -> LATCH.
  - LATCH: data_out=0 for T_RESET cycles; frame_done=1 on the final cycle. Next state is LOAD if CONTINUOUS=1, else IDLE with busy=0 from the next cycle.
- start while busy=1: ignored, not queued.
- reset mid-frame: outputs return to reset values on the next edge; any partial frame is abandoned.
- Frame length: 2 + LEDS_PER_CHAN*BITS_PER_LED*T_PERIOD + T_RESET cycles.

Optional Feature:
- Macro WS2812_BRIGHTNESS_EN.
- Defined: each 8-bit byte of the LED word is scaled as it is loaded into the shift register: out = (byte*(brightness+1))>>8. brightness=255 passes the value unchanged; brightness=0 gives 0. One multiplier per channel, shared across bytes or replicated per byte.
- brightness is sampled once per LED load; a change takes effect at the next LED.
- Not defined: brightness is ignored and words are sent unmodified.

Test Plan:
All scenarios use NUM_CHAN=2, LEDS_PER_CHAN=2, BITS_PER_LED=24, T_PERIOD=10, T_ON=6, T_OFF=3, T_RESET=20, CONTINUOUS=0.
- Write ch0 LED0=0x800001, ch1 LED0=0x000000, pulse start -> busy rises next cycle. After 2 LOAD cycles, ch0 first bit is high 6 clocks then low 4; ch1 first bit is high 3 clocks then low 7. The 24th bit of ch0 is high 6 clocks.
- Full frame -> exactly 48 bit periods, then 20 low cycles. frame_done pulses once on the last of those cycles; busy falls the cycle after. Total busy = 2+480+20 cycles.
- Pulse start again during DATA -> ignored; exactly one frame is emitted.
- During LED0 transmission, write ch0 LED1=0xFFFFFF -> LED1 is sent as all '1' bits in the same frame.
- Assert reset in the middle of LED1 -> data_out=0 and busy=0 on the next edge; IDLE until a new start.
- With WS2812_BRIGHTNESS_EN defined and brightness=127: word 0xFF8040 is sent as 0x7F4020. With brightness=255 it is sent as 0xFF8040.
